luhn_check_digit_tx: RTL and testbench

- Transmit-side counterpart of the Luhn validator: accepts the NUM_DIGITS-1 payload digits of a card number serially (BCD, MSB first) and computes the Luhn check digit.
- Re-emits the complete NUM_DIGITS-digit number serially, payload first and check digit last, as the stream the validator consumes.
- Sits between the digit source and the validator path.
- Valid/ready handshake on both sides; payload buffered internally.

---
 rtl/luhn_pkg.sv | 37 +++
 rtl/luhn_digit_acc.sv | 42 ++++
 rtl/luhn_check_digit_tx.sv | 182 ++++++++++++++++++
 tb/tb_luhn_check_digit_tx.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/luhn_pkg.sv
// -----------------------------------------------------------------------------
// luhn_pkg
// Shared Luhn helpers used by the check-digit transmitter and the validator.
//   bcd_t        : one BCD digit (4 bits)
//   DIGIT_MAX    : largest legal BCD digit value
//   luhn_double  : Luhn "doubling" of a digit (2d, minus 9 when 2d exceeds 9)
//   mod10_add    : modulo-10 sum of two digits that are each 0..9
// -----------------------------------------------------------------------------
package luhn_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX = 4'd9;

  // Doubling folds two-digit products back into one digit (digit sum of 2d).
  function automatic bcd_t luhn_double(input bcd_t d);
    logic [4:0] twice;
    logic [4:0] folded;
    twice  = {d, 1'b0};
    folded = twice - 5'd9;
    if (d < 4'd5) begin
      return twice[3:0];
    end
    return folded[3:0];
  endfunction

  // Both operands are at most 9, so a single conditional subtract suffices.
  function automatic bcd_t mod10_add(input bcd_t a, input bcd_t b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 5'd10) begin
      sum = sum - 5'd10;
    end
    return sum[3:0];
  endfunction

endpackage

// File: rtl/luhn_digit_acc.sv
// -----------------------------------------------------------------------------
// luhn_digit_acc
// Modulo-10 running Luhn sum. Each enabled cycle adds the incoming digit,
// doubled first when double_en is set. The sum never leaves 0..9.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   digit      in   BCD digit to add (must be 0..9 when en is high)
//   double_en  in   apply Luhn doubling to this digit
//   clr        in   synchronous clear, wins over en
//   en         in   add digit this cycle
//   acc        out  running sum modulo 10
// -----------------------------------------------------------------------------
module luhn_digit_acc
  import luhn_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  bcd_t digit,
  input  logic double_en,
  input  logic clr,
  input  logic en,
  output bcd_t acc
);

  bcd_t term;

  always_comb begin
    term = double_en ? luhn_double(digit) : digit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= mod10_add(acc, term);
    end
  end

endmodule

// File: rtl/luhn_check_digit_tx.sv
// -----------------------------------------------------------------------------
// luhn_check_digit_tx
// Collects NUM_DIGITS-1 payload digits (BCD, most significant first), computes
// the Luhn check digit and re-emits the full number: payload digits in arrival
// order followed by the check digit, flagged with out_last.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   in_digit     in   payload digit (BCD 0..9)
//   in_valid     in   in_digit valid
//   in_ready     out  a digit is accepted this cycle when in_valid is high
//   serial_out   out  outgoing digit
//   out_valid    out  serial_out valid
//   out_ready    in   downstream takes serial_out this cycle
//   out_last     out  serial_out carries the check digit
//   check_digit  out  last computed check digit, held until the next frame's
//                     calculation
//   err          out  one-cycle pulse after a non-BCD digit aborted the frame
// Flow: COLLECT (accept payload) -> CALC (one cycle) -> SEND (emit frame).
// -----------------------------------------------------------------------------
module luhn_check_digit_tx
  import luhn_pkg::*;
#(
  parameter int NUM_DIGITS = 16
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_digit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] serial_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [3:0] check_digit,
  output logic       err
);

  localparam int PAYLOAD = NUM_DIGITS - 1;
  localparam int CNT_W   = $clog2(NUM_DIGITS) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(PAYLOAD - 1);
  localparam logic [CNT_W-1:0] PAYLOAD_CNT = CNT_W'(PAYLOAD);

  // The rightmost payload digit is always doubled, so the doubled positions
  // are the indices sharing the parity of PAYLOAD-1.
  localparam logic LAST_PARITY = 1'(PAYLOAD - 1);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_CALC,
    ST_SEND
  } state_t;

  // Oldest digit ends up in the top slot once the payload is complete.
  typedef logic [PAYLOAD-1:0][3:0] pbuf_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  pbuf_t            buf_q;
  bcd_t             acc;

  logic accept;
  logic digit_bad;
  logic double_en;
  logic acc_en;
  logic acc_clr;

  function automatic pbuf_t shift_in(input pbuf_t b, input bcd_t d);
    pbuf_t r;
    r = b;
    for (int i = PAYLOAD - 1; i > 0; i--) begin
      r[i] = b[i-1];
    end
    r[0] = d;
    return r;
  endfunction

  function automatic bcd_t check_from_sum(input bcd_t sum);
    if (sum == 4'd0) begin
      return 4'd0;
    end
    return 4'd10 - sum;
  endfunction

  // in_ready is high only in COLLECT, so it doubles as the state qualifier.
  always_comb begin
    accept    = in_valid && in_ready;
    digit_bad = (in_digit > DIGIT_MAX);
    double_en = (cnt[0] == LAST_PARITY);
    acc_en    = accept && !digit_bad;
    // The sum is consumed in CALC and can be cleared on the same edge.
    acc_clr   = (accept && digit_bad) || (state == ST_CALC);
  end

  luhn_digit_acc u_acc (
    .clk       (clk),
    .rst       (rst),
    .digit     (in_digit),
    .double_en (double_en),
    .clr       (acc_clr),
    .en        (acc_en),
    .acc       (acc)
  );

  // cnt counts accepted payload digits in COLLECT and digits already loaded
  // into serial_out in SEND.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_COLLECT;
      cnt         <= '0;
      buf_q       <= '0;
      check_digit <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      serial_out  <= '0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_COLLECT: begin
          if (accept) begin
            if (digit_bad) begin
              err <= 1'b1;
              cnt <= '0;
            end else begin
              buf_q <= shift_in(buf_q, in_digit);
              if (cnt == LAST_IDX) begin
                cnt      <= '0;
                in_ready <= 1'b0;
                state    <= ST_CALC;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
        end

        ST_CALC: begin
          check_digit <= check_from_sum(acc);
          serial_out  <= buf_q[PAYLOAD-1];
          buf_q       <= shift_in(buf_q, 4'd0);
          out_valid   <= 1'b1;
          out_last    <= 1'b0;
          cnt         <= CNT_ONE;
          state       <= ST_SEND;
        end

        ST_SEND: begin
          // out_valid is always high here; holding when out_ready is low
          // keeps serial_out/out_last stable during a stall.
          if (out_ready) begin
            if (out_last) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              serial_out <= '0;
              cnt        <= '0;
              in_ready   <= 1'b1;
              state      <= ST_COLLECT;
            end else if (cnt == PAYLOAD_CNT) begin
              serial_out <= check_digit;
              out_last   <= 1'b1;
            end else begin
              serial_out <= buf_q[PAYLOAD-1];
              buf_q      <= shift_in(buf_q, 4'd0);
              cnt        <= cnt + CNT_ONE;
            end
          end
        end

        default: begin
          state    <= ST_COLLECT;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_luhn_check_digit_tx.sv
module tb_luhn_check_digit_tx;

  localparam int NUM_DIGITS = 16;
  localparam int PAYLOAD    = NUM_DIGITS - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] in_digit = 4'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] serial_out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic [3:0] check_digit;
  logic       err;

  int total = 0;
  int bad   = 0;

  int got_q[$];
  int last_q[$];
  int lat, stab_err, rdy_err, rcv_to, drv_to, send_cycles;

  always #5 clk = ~clk;

  luhn_check_digit_tx #(.NUM_DIGITS(NUM_DIGITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_digit    (in_digit),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .serial_out  (serial_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .check_digit (check_digit),
    .err         (err)
  );

  // Textbook Luhn: walking from the right, every other digit starting with the
  // rightmost payload digit is doubled (digit sum of the product).
  function automatic int luhn_ref(input int p[$]);
    int s;
    int d;
    s = 0;
    for (int j = 0; j < p.size(); j++) begin
      d = p[p.size() - 1 - j];
      if (j % 2 == 0) begin
        d = d * 2;
        if (d > 9) d = d - 9;
      end
      s = s + d;
    end
    return (10 - (s % 10)) % 10;
  endfunction

  function automatic int stream_errors(input int p[$]);
    int e;
    int exp[$];
    e = 0;
    exp = p;
    exp.push_back(luhn_ref(p));
    if (got_q.size() != exp.size()) e++;
    for (int i = 0; i < got_q.size() && i < exp.size(); i++) begin
      if (got_q[i] != exp[i]) e++;
      if (last_q[i] != ((i == exp.size() - 1) ? 1 : 0)) e++;
    end
    return e;
  endfunction

  function automatic void rand_payload(output int p[$]);
    p.delete();
    for (int i = 0; i < PAYLOAD; i++) p.push_back(int'($urandom_range(9)));
  endfunction

  // Presents digits on in_valid until all are accepted; called at a negedge
  // and returns at the negedge following the last accepting edge.
  task automatic drive_payload(input int d[$]);
    int i;
    int guard;
    logic hs;
    i = 0;
    guard = 0;
    drv_to = 0;
    while (i < d.size() && guard < 200) begin
      in_digit = 4'(d[i]);
      in_valid = 1'b1;
      hs = in_ready;
      @(negedge clk);
      if (hs === 1'b1) i++;
      guard++;
    end
    if (i < d.size()) drv_to = 1;
  endtask

  // Collects one output frame with random backpressure, recording stalls that
  // changed the output and any cycle where in_ready was high during SEND.
  task automatic receive_frame(input int stall_pct);
    int waits, cyc, prev_stall, prev_d, prev_l, done;
    got_q.delete();
    last_q.delete();
    stab_err = 0; rdy_err = 0; rcv_to = 0;
    waits = 0; cyc = 0; prev_stall = 0; prev_d = 0; prev_l = 0; done = 0;
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    lat = waits + 1;
    if (out_valid !== 1'b1) rcv_to = 1;
    while (done == 0 && rcv_to == 0) begin
      if (out_valid === 1'b1) begin
        if (in_ready !== 1'b0) rdy_err++;
        if (prev_stall != 0 && (serial_out !== 4'(prev_d) || out_last !== 1'(prev_l))) stab_err++;
        if (int'($urandom_range(99)) >= stall_pct) begin
          out_ready = 1'b1;
          got_q.push_back(int'(serial_out));
          last_q.push_back(int'(out_last));
          done = (out_last === 1'b1) ? 1 : 0;
          prev_stall = 0;
        end else begin
          out_ready = 1'b0;
          prev_stall = 1;
          prev_d = int'(serial_out);
          prev_l = int'(out_last);
        end
      end else begin
        out_ready = 1'b0;
        done = 1;
      end
      @(negedge clk);
      cyc++;
      if (cyc > 2000) rcv_to = 1;
    end
    out_ready = 1'b0;
    send_cycles = cyc;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
    total++; if (serial_out !== 4'd0) begin bad++; $display("FAIL reset_serial_out got=%0d exp=0", serial_out); end
    total++; if (check_digit !== 4'd0) begin bad++; $display("FAIL reset_check_digit got=%0d exp=0", check_digit); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_known_vector();
    int p[$];
    int e;
    p = '{4,5,3,9,1,4,8,8,0,3,4,3,6,4,6};
    drive_payload(p);
    in_valid = 1'b0;
    receive_frame(0);
    e = stream_errors(p);
    total++; if (drv_to + rcv_to != 0) begin bad++; $display("FAIL known_timeout got=%0d exp=0", drv_to + rcv_to); end
    total++; if (lat != 2) begin bad++; $display("FAIL known_latency got=%0d exp=2", lat); end
    total++; if (e != 0) begin bad++; $display("FAIL known_stream got=%0d_errors exp=0", e); end
    total++; if (check_digit !== 4'd7) begin bad++; $display("FAIL known_check got=%0d exp=7", check_digit); end
    total++; if (send_cycles != NUM_DIGITS) begin bad++; $display("FAIL known_throughput got=%0d exp=%0d", send_cycles, NUM_DIGITS); end
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL known_frame_end got=%b%b exp=10", in_ready, out_valid); end
  endtask

  task automatic test_edge_payloads();
    int p[$];
    int e;
    int exp_chk;
    for (int k = 0; k < 3; k++) begin
      p.delete();
      for (int i = 0; i < PAYLOAD - 1; i++) p.push_back(0);
      p.push_back((k == 0) ? 0 : (k == 1) ? 1 : 9);
      exp_chk = (k == 0) ? 0 : (k == 1) ? 8 : 1;
      drive_payload(p);
      in_valid = 1'b0;
      receive_frame(0);
      e = stream_errors(p);
      total++; if (check_digit !== 4'(exp_chk)) begin bad++; $display("FAIL edge_check case=%0d got=%0d exp=%0d", k, check_digit, exp_chk); end
      total++; if (e != 0 || rcv_to != 0) begin bad++; $display("FAIL edge_stream case=%0d got=%0d_errors exp=0", k, e); end
    end
  endtask

  task automatic test_backpressure();
    int p[$];
    int e;
    p = '{4,5,3,9,1,4,8,8,0,3,4,3,6,4,6};
    drive_payload(p);
    in_valid = 1'b0;
    receive_frame(45);
    e = stream_errors(p);
    total++; if (stab_err != 0) begin bad++; $display("FAIL bp_stable got=%0d_changes exp=0", stab_err); end
    total++; if (rdy_err != 0) begin bad++; $display("FAIL bp_in_ready got=%0d_cycles exp=0", rdy_err); end
    total++; if (e != 0 || rcv_to != 0) begin bad++; $display("FAIL bp_stream got=%0d_errors exp=0", e); end
    total++; if (check_digit !== 4'd7) begin bad++; $display("FAIL bp_check got=%0d exp=7", check_digit); end
  endtask

  task automatic test_bad_digit();
    int p[$];
    int q[$];
    int e;
    int seen;
    p = '{4,5,3,9,1,10};
    drive_payload(p);
    in_valid = 1'b0;
    total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_err_pulse got=%b exp=1", err); end
    @(negedge clk);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL bad_err_width got=%b exp=0", err); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
      @(negedge clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL bad_no_frame got=%0d_cycles exp=0", seen); end
    q = '{4,5,3,9,1,4,8,8,0,3,4,3,6,4,6};
    drive_payload(q);
    in_valid = 1'b0;
    receive_frame(0);
    e = stream_errors(q);
    total++; if (check_digit !== 4'd7) begin bad++; $display("FAIL bad_recover_check got=%0d exp=7", check_digit); end
    total++; if (e != 0 || rcv_to != 0) begin bad++; $display("FAIL bad_recover_stream got=%0d_errors exp=0", e); end
  endtask

  task automatic test_reset_mid_send();
    int p[$];
    int e;
    int hs;
    int guard;
    int seen;
    rand_payload(p);
    drive_payload(p);
    in_valid = 1'b0;
    hs = 0;
    guard = 0;
    out_ready = 1'b1;
    while (hs < 5 && guard < 50) begin
      if (out_valid === 1'b1) hs++;
      @(negedge clk);
      guard++;
    end
    total++; if (hs != 5) begin bad++; $display("FAIL rstmid_emitted got=%0d exp=5", hs); end
    out_ready = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    total++; if (check_digit !== 4'd0 || out_last !== 1'b0) begin bad++; $display("FAIL rstmid_regs got=%0d/%b exp=0/0", check_digit, out_last); end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_partial got=%0d_cycles exp=0", seen); end
    rand_payload(p);
    drive_payload(p);
    in_valid = 1'b0;
    receive_frame(20);
    e = stream_errors(p);
    total++; if (check_digit !== 4'(luhn_ref(p))) begin bad++; $display("FAIL rstmid_new_check got=%0d exp=%0d", check_digit, luhn_ref(p)); end
    total++; if (e != 0 || rcv_to != 0) begin bad++; $display("FAIL rstmid_new_stream got=%0d_errors exp=0", e); end
  endtask

  task automatic test_back_to_back();
    int a[$];
    int b[$];
    int e;
    rand_payload(a);
    rand_payload(b);
    drive_payload(a);
    // keep offering B's first digit while A is being computed and sent
    in_valid = 1'b1;
    in_digit = 4'(b[0]);
    receive_frame(0);
    e = stream_errors(a);
    total++; if (rdy_err != 0) begin bad++; $display("FAIL b2b_a_in_ready got=%0d_cycles exp=0", rdy_err); end
    total++; if (e != 0 || rcv_to != 0) begin bad++; $display("FAIL b2b_a_stream got=%0d_errors exp=0", e); end
    drive_payload(b);
    in_valid = 1'b1;
    in_digit = 4'($urandom_range(9));
    receive_frame(0);
    in_valid = 1'b0;
    e = stream_errors(b);
    total++; if (rdy_err != 0) begin bad++; $display("FAIL b2b_b_in_ready got=%0d_cycles exp=0", rdy_err); end
    total++; if (e != 0 || rcv_to != 0 || drv_to != 0) begin bad++; $display("FAIL b2b_b_stream got=%0d_errors exp=0", e); end
    total++; if (check_digit !== 4'(luhn_ref(b))) begin bad++; $display("FAIL b2b_b_check got=%0d exp=%0d", check_digit, luhn_ref(b)); end
  endtask

  task automatic test_random_frames();
    int p[$];
    int e;
    for (int k = 0; k < 6; k++) begin
      rand_payload(p);
      drive_payload(p);
      in_valid = 1'b0;
      receive_frame(30);
      e = stream_errors(p);
      total++; if (e != 0 || rcv_to != 0 || stab_err != 0) begin bad++; $display("FAIL rand_stream frame=%0d got=%0d_errors/%0d_stalls exp=0", k, e, stab_err); end
      total++; if (check_digit !== 4'(luhn_ref(p))) begin bad++; $display("FAIL rand_check frame=%0d got=%0d exp=%0d", k, check_digit, luhn_ref(p)); end
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_edge_payloads();
    test_backpressure();
    test_bad_digit();
    test_reset_mid_send();
    test_back_to_back();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
